// File: rtl/as_rv32i_writeback.sv
// RV32I writeback stage: retires instructions, waits for and formats load data, drives the regfile write port.
// Optional macro AS_RV32I_WB_FORWARD_EN adds combinational o_fwd_* bypass outputs.
module as_rv32i_writeback #(
   parameter int INSTRET_W = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_ce,
   input  logic                 i_wr_rd,
   input  logic [4:0]           i_rd_addr,
   input  logic [31:0]          i_alu_result,
   input  logic                 i_is_load,
   input  logic [2:0]           i_funct3,
   input  logic                 i_dmem_ack,
   input  logic [31:0]          i_dmem_rdata,
   output logic                 o_wr,
   output logic [4:0]           o_rd_addr,
   output logic [31:0]          o_rd,
   output logic                 o_ce,
   output logic                 o_stall,
   output logic [INSTRET_W-1:0] o_instret
`ifdef AS_RV32I_WB_FORWARD_EN
   ,
   output logic                 o_fwd_valid,
   output logic [4:0]           o_fwd_addr,
   output logic [31:0]          o_fwd_data
`endif
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic                   wr_q, wr_d;
   logic [4:0]             rd_addr_q, rd_addr_d;
   logic [31:0]            rd_q, rd_d;
   logic                   ce_q, ce_d;
   logic [INSTRET_W-1:0]   instret_q, instret_d;

   // Fields of a load waiting for its data-memory response
   logic                   cap_wr_rd_q, cap_wr_rd_d;
   logic [4:0]             cap_rd_addr_q, cap_rd_addr_d;
   logic [2:0]             cap_funct3_q, cap_funct3_d;
   logic [1:0]             cap_addr_q, cap_addr_d;

   function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                            input logic [1:0]  a,
                                            input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      case (a)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = a[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  fmt_load = {{24{b[7]}}, b};
         3'b001:  fmt_load = {{16{h[15]}}, h};
         3'b100:  fmt_load = {24'd0, b};
         3'b101:  fmt_load = {16'd0, h};
         default: fmt_load = w;
      endcase
   endfunction

   always_comb begin
      state_d       = state_q;
      wr_d          = 1'b0;
      ce_d          = 1'b0;
      rd_addr_d     = rd_addr_q;
      rd_d          = rd_q;
      cap_wr_rd_d   = cap_wr_rd_q;
      cap_rd_addr_d = cap_rd_addr_q;
      cap_funct3_d  = cap_funct3_q;
      cap_addr_d    = cap_addr_q;
      o_stall       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_ce) begin
               if (i_is_load && !i_dmem_ack) begin
                  cap_wr_rd_d   = i_wr_rd;
                  cap_rd_addr_d = i_rd_addr;
                  cap_funct3_d  = i_funct3;
                  cap_addr_d    = i_alu_result[1:0];
                  o_stall       = 1'b1;
                  state_d       = ST_WAIT;
               end else begin
                  ce_d      = 1'b1;
                  wr_d      = i_wr_rd && (i_rd_addr != 5'd0);
                  rd_addr_d = i_rd_addr;
                  rd_d      = i_is_load ? fmt_load(i_funct3, i_alu_result[1:0], i_dmem_rdata)
                                        : i_alu_result;
               end
            end
         end
         ST_WAIT: begin
            // A new i_ce here is a protocol violation and is deliberately dropped
            if (i_dmem_ack) begin
               ce_d      = 1'b1;
               wr_d      = cap_wr_rd_q && (cap_rd_addr_q != 5'd0);
               rd_addr_d = cap_rd_addr_q;
               rd_d      = fmt_load(cap_funct3_q, cap_addr_q, i_dmem_rdata);
               state_d   = ST_IDLE;
            end else begin
               o_stall = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      instret_d = ce_d ? instret_q + INSTRET_W'(1) : instret_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= ST_IDLE;
         wr_q          <= 1'b0;
         rd_addr_q     <= 5'd0;
         rd_q          <= 32'd0;
         ce_q          <= 1'b0;
         instret_q     <= '0;
         cap_wr_rd_q   <= 1'b0;
         cap_rd_addr_q <= 5'd0;
         cap_funct3_q  <= 3'd0;
         cap_addr_q    <= 2'd0;
      end else begin
         state_q       <= state_d;
         wr_q          <= wr_d;
         rd_addr_q     <= rd_addr_d;
         rd_q          <= rd_d;
         ce_q          <= ce_d;
         instret_q     <= instret_d;
         cap_wr_rd_q   <= cap_wr_rd_d;
         cap_rd_addr_q <= cap_rd_addr_d;
         cap_funct3_q  <= cap_funct3_d;
         cap_addr_q    <= cap_addr_d;
      end
   end

   assign o_wr      = wr_q;
   assign o_rd_addr = rd_addr_q;
   assign o_rd      = rd_q;
   assign o_ce      = ce_q;
   assign o_instret = instret_q;

`ifdef AS_RV32I_WB_FORWARD_EN
   // Next-cycle view of the write port, for decode-stage RAW bypass
   assign o_fwd_valid = wr_d;
   assign o_fwd_addr  = rd_addr_d;
   assign o_fwd_data  = rd_d;
`endif

endmodule

// File: doc/as_rv32i_writeback.md
Name: as_rv32i_writeback

Overview:
- Final pipeline stage (WRITEBACK).
- Takes completed instructions from the memory stage, waits for data-memory load responses, and formats load data (byte/half/word, signed/unsigned).
- Drives the registered write port of the base register file: rd address, rd data and write enable.
- Also provides a stall to upstream stages and a retired-instruction counter.

Parameters:
- INSTRET_W, 32, width of retired-instruction counter o_instret.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_ce  input  1  valid instruction from memory stage this cycle
- i_wr_rd  input  1  instruction writes rd
- i_rd_addr  input  5  destination register address
- i_alu_result  input  32  rd value for non-loads; load byte address for loads (bits [1:0] used)
- i_is_load  input  1  instruction is a load
- i_funct3  input  3  load type
- i_dmem_ack  input  1  load data valid on i_dmem_rdata
- i_dmem_rdata  input  32  raw word read from data memory
- o_wr  output  1  regfile write enable
- o_rd_addr  output  5  regfile write address
- o_rd  output  32  regfile write data
- o_ce  output  1  one-cycle retire pulse
- o_stall  output  1  upstream must hold; i_ce must not be asserted while high
- o_instret  output  INSTRET_W  count of retired instructions

Behaviour:
- Reset: state IDLE; o_wr=0, o_rd_addr=0, o_rd=0, o_ce=0, o_stall=0, o_instret=0.
- o_wr, o_rd_addr, o_rd and o_ce are registered.
- o_stall is combinational from state and inputs.
- State IDLE:
  - i_ce && !i_is_load: next cycle o_ce=1, o_rd_addr=i_rd_addr, o_rd=i_alu_result, o_wr=i_wr_rd && (i_rd_addr!=0). Latency 1.
  - i_ce && i_is_load && i_dmem_ack: same as above, but o_rd = formatted(i_dmem_rdata). Latency 1.
  - i_ce && i_is_load && !i_dmem_ack: capture rd_addr, wr_rd, funct3, addr[1:0]; go to WAIT. o_stall=1 this cycle.
  - !i_ce: o_wr=0, o_ce=0 next cycle. o_rd_addr and o_rd hold their previous values.
- State WAIT:
  - o_stall=1 while !i_dmem_ack.
  - i_dmem_ack: o_stall=0 this cycle. Next cycle, write the formatted data using the captured fields, o_ce=1, state returns to IDLE.
  - i_ce in WAIT is ignored (protocol violation).
- Back-to-back: an instruction may be accepted in IDLE in the cycle directly after any retire. Throughput is 1 per cycle for non-loads and for loads acked in the same cycle.
- Load formatting (a = addr[1:0]):
  - 000 LB: byte a, sign-extended.
  - 001 LH: half a[1], sign-extended; a[0] ignored.
  - 010 LW: full word; a ignored.
  - 100 LBU: byte a, zero-extended.
  - 101 LHU: half a[1], zero-extended.
  - 011/110/111: treated as LW.
- rd=x0: o_wr stays 0, but o_ce still pulses and o_instret still counts.
- o_instret increments by 1 on every cycle o_ce=1 and wraps from 2^INSTRET_W-1 to 0.
- Reset mid-WAIT: the pending load is dropped with no write and no count; o_stall=0 in the cycle after reset.
- An i_dmem_ack received in IDLE without i_ce && i_is_load is ignored.

Optional Feature:
- Macro: AS_RV32I_WB_FORWARD_EN.
- When defined, adds outputs o_fwd_valid (1), o_fwd_addr (5) and o_fwd_data (32).
  - These are combinational copies of the value that will appear on o_wr/o_rd_addr/o_rd next cycle.
  - o_fwd_valid is set when a write is being accepted: IDLE non-load, IDLE load with ack, or WAIT with ack, in each case with wr_rd and rd!=0.
  - Decode uses them to bypass regfile read-after-write hazards.
- When not defined, the ports are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then i_ce non-load, rd=5, alu=0x1234_5678, wr_rd=1 -> next cycle o_wr=1, o_rd_addr=5, o_rd=0x12345678, o_ce=1, o_instret=1.
- LB at addr 0x...03 with rdata=0x80FF_0000 and ack in the same cycle -> next cycle o_rd=0xFFFFFF80. Same stimulus as LBU -> o_rd=0x00000080.
- LH at addr 0x...02 with rdata=0x8001_7FFF, ack delayed 3 cycles -> o_stall=1 for the accept cycle plus the next 2; o_stall=0 in the ack cycle; write o_rd=0xFFFF8001 one cycle after the ack; i_ce asserted during WAIT causes no extra retire.
- Non-load with rd=0, wr_rd=1 -> o_wr=0, o_ce=1, o_instret increments.
- Load pending in WAIT, then i_rst pulsed 1 cycle, then ack -> no write, o_instret=0, o_stall=0.
- INSTRET_W=4: retire 17 instructions back-to-back -> o_instret wraps to 1. With AS_RV32I_WB_FORWARD_EN defined, o_fwd_* equals next-cycle o_wr/o_rd_addr/o_rd on every cycle.
